// File: rtl/clk_pattern_monitor_pkg.sv
// rtl/clk_pattern_monitor_pkg.sv - shared types and defaults for the clock-pattern monitor
package clk_pat_pkg;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } mon_state_t;

    localparam int PAT_W_DEF = 16;

endpackage

// File: rtl/clk_pattern_monitor_shift_window.sv
// rtl/clk_pattern_monitor_shift_window.sv - serial sample window with saturating fill count
module pattern_shift_window
    import clk_pat_pkg::*;
#(
    parameter int PAT_W = PAT_W_DEF
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             en,
    input  logic             din,
    output logic [PAT_W-1:0] win,
    output logic [PAT_W-1:0] win_nxt,
    output logic             full_nxt
);

    localparam int FILL_W = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W);
    localparam logic [FILL_W-1:0] FILL_PRE = FILL_W'(PAT_W - 1);

    logic [FILL_W-1:0] fill;

    // Look-ahead view of the window so the search compare sees this cycle's sample
    always_comb begin
        win_nxt  = {din, win[PAT_W-1:1]};
        full_nxt = (fill >= FILL_PRE);
    end

    // Shift newest sample in at the top; disabling the monitor empties the window
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            win  <= '0;
            fill <= '0;
        end else if (!en) begin
            win  <= '0;
            fill <= '0;
        end else begin
            win <= win_nxt;
            if (fill != FILL_MAX) begin
                fill <= fill + 1'b1;
            end
        end
    end

endmodule

// File: rtl/clk_pattern_monitor.sv
// rtl/clk_pattern_monitor.sv - boundary search, lock tracking and error counting for the clock pattern
module clk_pattern_monitor
    import clk_pat_pkg::*;
#(
    parameter int   PAT_W       = PAT_W_DEF,
    parameter int   LOCK_CNT    = 4,
    parameter int   LOSS_THRESH = 2,
    parameter int   ERR_W       = 8,
    localparam int  PH_W        = $clog2(PAT_W)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             en,
    input  logic             din,
    input  logic [PAT_W-1:0] exp_pat,
    input  logic             clr_err,
    output logic             locked,
    output logic [PH_W-1:0]  phase,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_cnt,
    output logic [PAT_W-1:0] pat_capture
);

    localparam int GOOD_W = $clog2(LOCK_CNT + 1);
    localparam int BAD_W  = $clog2(LOSS_THRESH + 1);
    localparam logic [PH_W-1:0]   PH_LAST  = PH_W'(PAT_W - 1);
    localparam logic [GOOD_W-1:0] GOOD_TGT = GOOD_W'(LOCK_CNT);
    localparam logic [BAD_W-1:0]  BAD_TGT  = BAD_W'(LOSS_THRESH);
    localparam logic [ERR_W-1:0]  ERR_MAX  = '1;

    mon_state_t        state;
    logic [GOOD_W-1:0] good;
    logic [BAD_W-1:0]  bad;
    logic              period_err;
    logic [PAT_W-1:0]  win;
    logic [PAT_W-1:0]  win_nxt;
    logic              full_nxt;
    logic              mismatch;
    logic              wrap;
    logic [GOOD_W-1:0] good_inc;
    logic [BAD_W-1:0]  bad_inc;

    pattern_shift_window #(
        .PAT_W(PAT_W)
    ) u_window (
        .clk      (clk),
        .rstn     (rstn),
        .en       (en),
        .din      (din),
        .win      (win),
        .win_nxt  (win_nxt),
        .full_nxt (full_nxt)
    );

    assign pat_capture = win;

    // Per-bit compare against the expected pattern at the tracked phase
    always_comb begin
        mismatch = din ^ exp_pat[phase];
        wrap     = (phase == PH_LAST);
        good_inc = good + 1'b1;
        bad_inc  = bad + 1'b1;
    end

    // Acquisition / verification / lock state machine with phase and period counters
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= SEARCH;
            phase      <= '0;
            locked     <= 1'b0;
            good       <= '0;
            bad        <= '0;
            period_err <= 1'b0;
            err_pulse  <= 1'b0;
        end else begin
            err_pulse <= 1'b0;
            if (!en) begin
                state      <= SEARCH;
                phase      <= '0;
                locked     <= 1'b0;
                good       <= '0;
                bad        <= '0;
                period_err <= 1'b0;
            end else begin
                case (state)
                    SEARCH: begin
                        if (full_nxt && (win_nxt == exp_pat)) begin
                            state      <= VERIFY;
                            phase      <= '0;
                            good       <= '0;
                            bad        <= '0;
                            period_err <= 1'b0;
                        end
                    end
                    VERIFY: begin
                        if (mismatch) begin
                            // Window is kept, so the search picks up again next cycle
                            state <= SEARCH;
                            phase <= '0;
                        end else begin
                            phase <= wrap ? '0 : phase + 1'b1;
                            if (wrap) begin
                                good <= good_inc;
                                if (good_inc == GOOD_TGT) begin
                                    state  <= LOCKED;
                                    locked <= 1'b1;
                                end
                            end
                        end
                    end
                    LOCKED: begin
                        phase <= wrap ? '0 : phase + 1'b1;
                        if (mismatch) begin
                            err_pulse <= 1'b1;
                        end
                        if (wrap) begin
                            period_err <= 1'b0;
                            if (period_err || mismatch) begin
                                if (bad_inc == BAD_TGT) begin
                                    state  <= SEARCH;
                                    locked <= 1'b0;
                                    bad    <= '0;
                                end else begin
                                    bad <= bad_inc;
                                end
                            end else begin
                                bad <= '0;
                            end
                        end else if (mismatch) begin
                            period_err <= 1'b1;
                        end
                    end
                    default: begin
                        state <= SEARCH;
                        phase <= '0;
                    end
                endcase
            end
        end
    end

    // Saturating count of mismatched bits seen while locked; clear has priority
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            err_cnt <= '0;
        end else if (clr_err) begin
            err_cnt <= '0;
        end else if (en && (state == LOCKED) && mismatch && (err_cnt != ERR_MAX)) begin
            err_cnt <= err_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_clk_pattern_monitor.sv
// tb/tb_clk_pattern_monitor.sv - self-checking bench for clk_pattern_monitor
module tb_clk_pattern_monitor;

    localparam int SRCH = 0;
    localparam int VER  = 1;
    localparam int LCK  = 2;

    logic        clk = 1'b0;
    logic        rstn;
    logic        en;
    logic        din;
    logic        clr_err;
    logic [15:0] exp_pat;
    logic        locked;
    logic [3:0]  phase;
    logic        err_pulse;
    logic [7:0]  err_cnt;
    logic [15:0] pat_capture;

    int checks = 0;
    int errors = 0;
    int pulses = 0;
    int gen_ph = 0;

    // reference model state
    bit mq[$];
    int m_fill, m_mode, m_phase, m_good, m_bad, m_errcnt;
    bit m_perr, m_pulse;

    typedef struct {
        int          start_ph;
        logic [15:0] pat;
        int          lock_step;
    } vec_t;
    vec_t tbl[6];

    clk_pattern_monitor #(
        .PAT_W(16), .LOCK_CNT(4), .LOSS_THRESH(2), .ERR_W(8)
    ) dut (
        .clk(clk), .rstn(rstn), .en(en), .din(din), .exp_pat(exp_pat),
        .clr_err(clr_err), .locked(locked), .phase(phase), .err_pulse(err_pulse),
        .err_cnt(err_cnt), .pat_capture(pat_capture)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] mwin();
        logic [15:0] r;
        for (int i = 0; i < 16; i++) r[i] = mq[i];
        return r;
    endfunction

    function automatic void model_clear_acq();
        mq.delete();
        for (int i = 0; i < 16; i++) mq.push_back(1'b0);
        m_fill = 0; m_mode = SRCH; m_phase = 0; m_good = 0; m_bad = 0; m_perr = 0;
    endfunction

    function automatic void model_step(bit e, bit d, bit c, logic [15:0] p);
        bit mm;
        m_pulse = 0;
        if (!e) begin
            model_clear_acq();
        end else begin
            mq.push_back(d);
            void'(mq.pop_front());
            if (m_fill < 16) m_fill++;
            mm = (d != p[m_phase]);
            if (m_mode == SRCH) begin
                if (m_fill == 16 && mwin() == p) begin
                    m_mode = VER; m_phase = 0; m_good = 0;
                end
            end else if (m_mode == VER) begin
                if (mm) begin
                    m_mode = SRCH; m_phase = 0;
                end else begin
                    m_phase = (m_phase + 1) % 16;
                    if (m_phase == 0) begin
                        m_good++;
                        if (m_good == 4) begin
                            m_mode = LCK; m_bad = 0; m_perr = 0;
                        end
                    end
                end
            end else begin
                if (mm) begin
                    m_pulse = 1;
                    m_perr = 1;
                    if (m_errcnt < 255) m_errcnt++;
                end
                m_phase = (m_phase + 1) % 16;
                if (m_phase == 0) begin
                    if (m_perr) m_bad++;
                    else m_bad = 0;
                    m_perr = 0;
                    if (m_bad == 2) begin
                        m_mode = SRCH; m_bad = 0;
                    end
                end
            end
        end
        if (c) m_errcnt = 0;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0d want=%0d t=%0t", nm, got, want, $time);
        end
    endtask

    task automatic step(input bit e, input bit d, input bit c);
        en = e; din = d; clr_err = c;
        @(posedge clk);
        #1;
        model_step(e, d, c, exp_pat);
        if (err_pulse === 1'b1) pulses++;
        checks++;
        if (locked !== (m_mode == LCK) || phase !== 4'(m_phase) || err_pulse !== m_pulse ||
            err_cnt !== 8'(m_errcnt) || pat_capture !== mwin()) begin
            errors++;
            $display("FAIL model_cycle t=%0t got L=%b ph=%0d p=%b c=%0d cap=%h want L=%b ph=%0d p=%b c=%0d cap=%h",
                     $time, locked, phase, err_pulse, err_cnt, pat_capture,
                     (m_mode == LCK), m_phase, m_pulse, m_errcnt, mwin());
        end
    endtask

    task automatic gen_step(input bit flip, input bit c);
        step(1'b1, exp_pat[gen_ph] ^ flip, c);
        gen_ph = (gen_ph + 1) % 16;
    endtask

    // flip_ph: -1 none, 99 every bit, else the single phase to corrupt
    task automatic run_period(input int flip_ph, input bit clr_first);
        for (int k = 0; k < 16; k++) begin
            gen_step((flip_ph == 99) || (gen_ph == flip_ph), clr_first && (k == 0));
        end
    endtask

    task automatic acquire(input int start_ph, output int found);
        step(1'b0, 1'b0, 1'b0);
        gen_ph = start_ph;
        found = 0;
        for (int k = 1; k <= 200 && found == 0; k++) begin
            gen_step(1'b0, 1'b0);
            if (locked === 1'b1) found = k;
        end
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_locked"}, locked, 0);
        chk({nm, "_phase"}, phase, 0);
        chk({nm, "_pulse"}, err_pulse, 0);
        chk({nm, "_cnt"}, err_cnt, 0);
        chk({nm, "_cap"}, pat_capture, 0);
    endtask

    initial begin
        int found;
        int anylock;

        tbl[0] = '{0,  16'hA5C3, 80};
        tbl[1] = '{5,  16'hA5C3, 91};
        tbl[2] = '{15, 16'hA5C3, 81};
        tbl[3] = '{1,  16'hA5C3, 95};
        tbl[4] = '{7,  16'hFFFF, 80};
        tbl[5] = '{3,  16'hAAAA, 81};

        rstn = 1'b0; en = 1'b0; din = 1'b0; clr_err = 1'b0; exp_pat = 16'hA5C3;
        #12;
        chk_all_zero("reset");
        model_clear_acq();
        m_errcnt = 0;
        rstn = 1'b1;

        // table: lock latency from various starting phases and patterns
        for (int i = 0; i < 6; i++) begin
            exp_pat = tbl[i].pat;
            acquire(tbl[i].start_ph, found);
            chk($sformatf("lock_step_%0d", i), found, tbl[i].lock_step);
            chk($sformatf("lock_phase_%0d", i), phase, 0);
            chk($sformatf("lock_errcnt_%0d", i), err_cnt, 0);
        end

        // single flipped periods keep lock; two consecutive drop it
        exp_pat = 16'hA5C3;
        acquire(0, found);
        chk("relock", found, 80);
        run_period(3, 1'b1);
        run_period(-1, 1'b0);
        run_period(3, 1'b0);
        run_period(-1, 1'b0);
        chk("single_err_keeps_lock", locked, 1);
        chk("single_err_cnt", err_cnt, 2);
        run_period(-1, 1'b1);
        pulses = 0;
        run_period(5, 1'b0);
        chk("one_bad_period_locked", locked, 1);
        run_period(5, 1'b0);
        chk("two_bad_unlock", locked, 0);
        chk("two_bad_phase", phase, 0);
        chk("two_bad_pulses", pulses, 2);
        chk("two_bad_cnt", err_cnt, 2);

        // saturation of the error counter
        acquire(0, found);
        chk("relock_sat", found, 80);
        run_period(-1, 1'b1);
        for (int i = 0; i < 19; i++) begin
            run_period(99, 1'b0);
            run_period(-1, 1'b0);
        end
        chk("sat_cnt", err_cnt, 255);
        chk("sat_locked", locked, 1);
        gen_step(1'b1, 1'b1);
        chk("clr_wins_cnt", err_cnt, 0);
        chk("clr_wins_pulse", err_pulse, 1);
        for (int k = 0; k < 15; k++) gen_step(1'b0, 1'b0);
        run_period(-1, 1'b0);

        // en=0 while locked, then re-enable
        run_period(2, 1'b0);
        for (int k = 0; k < 7; k++) gen_step(1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        chk("en_off_locked", locked, 0);
        chk("en_off_phase", phase, 0);
        chk("en_off_cnt_held", err_cnt, 1);
        gen_ph = 0;
        found = 0;
        for (int k = 1; k <= 80 && found == 0; k++) begin
            gen_step(1'b0, 1'b0);
            if (locked === 1'b1) found = k;
        end
        chk("reacquire", found, 80);

        // async reset mid-period
        for (int k = 0; k < 5; k++) gen_step(1'b0, 1'b0);
        #3 rstn = 1'b0;
        #1;
        chk_all_zero("async_rst");
        model_clear_acq();
        m_errcnt = 0;
        #2 rstn = 1'b1;

        // mismatch during second verify period: back to search, no error reporting
        step(1'b0, 1'b0, 1'b0);
        gen_ph = 0;
        pulses = 0;
        for (int k = 0; k < 32; k++) gen_step(1'b0, 1'b0);
        for (int k = 0; k < 6; k++) gen_step(1'b0, 1'b0);
        gen_step(1'b1, 1'b0);
        anylock = 0;
        for (int k = 0; k < 40; k++) begin
            gen_step(1'b0, 1'b0);
            if (locked !== 1'b0) anylock = 1;
        end
        chk("verify_fail_no_lock", anylock, 0);
        chk("verify_fail_pulses", pulses, 0);
        chk("verify_fail_cnt", err_cnt, 0);

        // randomized segments against the model
        for (int s = 0; s < 20; s++) begin
            int len;
            bit noise;
            exp_pat = 16'($urandom);
            step(1'b0, 1'b0, 1'b0);
            gen_ph = $urandom_range(0, 15);
            len = $urandom_range(100, 300);
            noise = ($urandom_range(0, 7) == 0);
            for (int k = 0; k < len; k++) begin
                if ($urandom_range(0, 199) == 0) begin
                    step(1'b0, 1'b0, $urandom_range(0, 31) == 0);
                    gen_ph = (gen_ph + 1) % 16;
                end else if (noise) begin
                    step(1'b1, 1'($urandom), $urandom_range(0, 31) == 0);
                    gen_ph = (gen_ph + 1) % 16;
                end else begin
                    gen_step($urandom_range(0, 63) == 0, $urandom_range(0, 31) == 0);
                end
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
